// File: rtl/crc16_serial_engine.sv
// Bit-serial CRC-16 engine: one message bit per clock, MSB first, 32-bit words.
// Optional CRC_CHAIN_EN lets a start with chain=1 continue from the previous CRC.
module crc16_serial_engine #(
  parameter logic [15:0] POLY   = 16'h8005,
  parameter logic [15:0] INIT   = 16'h0000,
  parameter logic [15:0] XOROUT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        start,
  input  logic        chain,
  output logic        busy,
  output logic        done,
  output logic [15:0] crc_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t      state;
  logic [15:0] crc;
  logic [31:0] sr;
  logic [4:0]  count;

  logic        fb;
  logic [15:0] next_crc;
  logic [15:0] load_crc;

  assign fb       = crc[15] ^ sr[31];
  assign next_crc = {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

`ifdef CRC_CHAIN_EN
  // The register holds the final pre-XOROUT value after each word, so chaining
  // simply skips the reload.
  assign load_crc = chain ? crc : INIT;
`else
  logic unused_chain;
  assign unused_chain = chain;
  assign load_crc     = INIT;
`endif

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      crc_out <= 16'h0000;
      crc     <= INIT;
      sr      <= 32'h0000_0000;
      count   <= 5'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sr    <= data_in;
            crc   <= load_crc;
            count <= 5'd0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // start is deliberately not looked at here: requests during a shift are dropped.
          crc   <= next_crc;
          sr    <= {sr[30:0], 1'b0};
          count <= count + 5'd1;
          if (count == 5'd31) begin
            crc_out <= next_crc ^ XOROUT;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_serial_engine.sv
// Directed bench for crc16_serial_engine: hand-computed CRC-16/0x8005 vectors,
// latency, ignored restarts, DONE hold, mid-shift reset and chain behaviour.
module tb_crc16_serial_engine;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        start;
  logic        chain;
  logic        busy;
  logic        done;
  logic [15:0] crc_out;

  int checks;
  int errors;

  crc16_serial_engine dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .start   (start),
    .chain   (chain),
    .busy    (busy),
    .done    (done),
    .crc_out (crc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one start and follow the word to completion. pulse_at >= 0 drives an
  // extra start (carrying 32'h3) on the edge that makes n reach pulse_at+1.
  task automatic run_word(input string tag, input logic [31:0] d, input logic ch,
                          input logic [15:0] exp, input int pulse_at);
    logic [15:0] prev;
    int n;
    prev = crc_out;
    @(negedge clk);
    data_in = d;
    chain   = ch;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chain = 1'b0;
    check({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (n == pulse_at) begin
        start   = 1'b1;
        data_in = 32'h0000_0003;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (n == 16) check({tag, "_crc_hold"}, 32'(crc_out), 32'(prev));
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd32);
    check({tag, "_crc"}, 32'(crc_out), 32'(exp));
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int stayed;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    chain   = 1'b0;
    data_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_crc", 32'(crc_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_word("zero", 32'h0000_0000, 1'b0, 16'h0000, -1);
    run_word("one",  32'h0000_0001, 1'b0, 16'h8005, -1);
    run_word("two",  32'h0000_0002, 1'b0, 16'h800F, -1);
    run_word("three", 32'h0000_0003, 1'b0, 16'h000A, -1);
    run_word("four", 32'h0000_0004, 1'b0, 16'h801B, -1);

    // Second start pulse mid-shift must be dropped entirely.
    run_word("ignored", 32'h0000_0001, 1'b0, 16'h8005, 9);
    stayed = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk);
      #1;
      if (done && !busy && crc_out == 16'h8005) stayed++;
    end
    check("done_hold_no_restart", 32'(stayed), 32'd35);

    // Restart from DONE: crc_out holds 8005 during shift, then becomes 800F.
    run_word("restart", 32'h0000_0002, 1'b0, 16'h800F, -1);

    // Reset at cycle 15 of a shift.
    @(negedge clk);
    data_in = 32'h0000_0001;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_crc", 32'(crc_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_word("after_rst", 32'h0000_0001, 1'b0, 16'h8005, -1);

    // Chain behaviour.
    run_word("chain_w0", 32'h0000_0000, 1'b0, 16'h0000, -1);
    run_word("chain_w1", 32'h0000_0001, 1'b1, 16'h8005, -1);
`ifdef CRC_CHAIN_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_word("chain_first", 32'h0000_0001, 1'b1, 16'h8005, -1);
`else
    run_word("chain_ignored", 32'h0000_0003, 1'b1, 16'h000A, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
